// File: rtl/uart_ram_dumper.sv
// uart_ram_dumper
//   Streams a block of RAM words out to a UART TX FIFO, one byte at a time,
//   least-significant byte of each word first.
//
// Ports
//   clk, rstb         : clock (rising edge) / asynchronous active-low reset
//   start             : one-cycle dump request, honoured only while idle
//   start_addr        : first word address, sampled on an accepted start
//   word_cnt          : number of words to dump (0 gives an immediate done)
//   abort             : abandon the current dump, no done pulse
//   busy              : high whenever a dump is in progress
//   done              : one-cycle pulse when a dump finishes normally
//   ram_rd_en/ram_addr: single-cycle RAM read strobe and word address
//   ram_rd_data       : RAM read data, valid the cycle after ram_rd_en
//   tx_wr_req/data    : byte offered to the TX FIFO, held until accepted
//   tx_wr_ready       : TX FIFO accepts a byte when tx_wr_req & tx_wr_ready

module uart_ram_dumper #(
    parameter int ADDR_LEN = 14,
    parameter int XLEN     = 32
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] start_addr,
    input  logic [ADDR_LEN:0]   word_cnt,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                ram_rd_en,
    output logic [ADDR_LEN-1:0] ram_addr,
    input  logic [XLEN-1:0]     ram_rd_data,
    output logic                tx_wr_req,
    output logic [7:0]          tx_wr_data,
    input  logic                tx_wr_ready
);

    localparam int NB   = XLEN / 8;
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW   = ADDR_LEN + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_SEND,
        S_NEXT
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_rd_en;
    logic [ADDR_LEN-1:0] r_addr;
    logic [CW-1:0]       r_rem;
    logic [XLEN-1:0]     r_buf;
    logic [IDXW-1:0]     r_idx;
    logic                r_tx_req;
    logic [7:0]          r_tx_data;

    logic                w_xfer;
    logic                w_last;
    logic [IDXW-1:0]     w_idx_nxt;
    logic [ADDR_LEN-1:0] w_addr_nxt;
    logic [CW-1:0]       w_rem_nxt;

    assign w_xfer     = r_tx_req & tx_wr_ready;
    assign w_last     = (r_idx == IDXW'(NB - 1));
    assign w_idx_nxt  = r_idx + IDXW'(1);
    assign w_addr_nxt = r_addr + ADDR_LEN'(1);   // natural wrap at 2^ADDR_LEN
    assign w_rem_nxt  = r_rem - CW'(1);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_rem     <= '0;
            r_buf     <= '0;
            r_idx     <= '0;
            r_tx_req  <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && r_state != S_IDLE) begin
                // A byte accepted this same cycle is already gone; just stop.
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_rd_en  <= 1'b0;
                r_tx_req <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            if (word_cnt != '0) begin
                                r_addr  <= start_addr;
                                r_rem   <= word_cnt;
                                r_rd_en <= 1'b1;
                                r_busy  <= 1'b1;
                                r_state <= S_READ;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_READ: begin
                        r_rd_en <= 1'b0;
                        r_state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        // Present byte 0 straight from the RAM bus so SEND
                        // starts with a valid byte on its first cycle.
                        r_buf     <= ram_rd_data;
                        r_idx     <= '0;
                        r_tx_req  <= 1'b1;
                        r_tx_data <= ram_rd_data[7:0];
                        r_state   <= S_SEND;
                    end
                    S_SEND: begin
                        if (w_xfer) begin
                            if (w_last) begin
                                r_tx_req <= 1'b0;
                                r_state  <= S_NEXT;
                            end else begin
                                r_idx     <= w_idx_nxt;
                                r_tx_data <= r_buf[8*int'(w_idx_nxt) +: 8];
                            end
                        end
                    end
                    S_NEXT: begin
                        r_rem  <= w_rem_nxt;
                        r_addr <= w_addr_nxt;
                        if (w_rem_nxt == '0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_rd_en <= 1'b1;
                            r_state <= S_READ;
                        end
                    end
                    default: begin
                        r_busy   <= 1'b0;
                        r_rd_en  <= 1'b0;
                        r_tx_req <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign ram_rd_en  = r_rd_en;
    assign ram_addr   = r_addr;
    assign tx_wr_req  = r_tx_req;
    assign tx_wr_data = r_tx_data;

endmodule

// File: doc/uart_ram_dumper.md
UART_RAM_DUMPER -- requirements
Module: uart_ram_dumper

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 14: RAM word-address width.
REQ-002 SHALL have parameter XLEN, default 32: RAM word width; XLEN/8 bytes per word.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rstb, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle dump request.
REQ-006 SHALL have port start_addr, input, ADDR_LEN: first word address, sampled on accepted start.
REQ-007 SHALL have port word_cnt, input, ADDR_LEN+1: words to dump, sampled on accepted start.
REQ-008 SHALL have port abort, input, 1: terminate dump.
REQ-009 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse on normal completion.
REQ-011 SHALL have port ram_rd_en, output, 1: RAM read strobe.
REQ-012 SHALL have port ram_addr, output, ADDR_LEN: RAM word address.
REQ-013 SHALL have port ram_rd_data, input, XLEN: RAM read data, valid the cycle after ram_rd_en.
REQ-014 SHALL have port tx_wr_req, output, 1: byte valid toward UART TX FIFO.
REQ-015 SHALL have port tx_wr_data, output, 8: byte toward UART TX FIFO.
REQ-016 SHALL have port tx_wr_ready, input, 1: TX FIFO can accept; byte transfers when tx_wr_req & tx_wr_ready.

Function
REQ-017 SHALL implement FSM states IDLE, READ, CAPTURE, SEND, NEXT.
REQ-018 IDLE: start=1 and word_cnt!=0 SHALL latch start_addr/word_cnt and go to READ next cycle.
REQ-019 IDLE: start=1 and word_cnt==0 SHALL pulse done next cycle, stay IDLE, issue no RAM read or byte.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 READ: ram_rd_en=1 for exactly one cycle with ram_addr = current address; go to CAPTURE.
REQ-022 CAPTURE: ram_rd_data SHALL be latched into a word buffer; byte index cleared to 0; go to SEND.
REQ-023 SEND: tx_wr_req=1, tx_wr_data = buffer byte[index], little-endian (bits 7:0 first).
REQ-024 tx_wr_req and tx_wr_data SHALL stay constant until transfer; on transfer index increments, next byte may be presented the following cycle (back-to-back at 1 byte/clk when tx_wr_ready held high).
REQ-025 Transfer of byte XLEN/8-1 SHALL go to NEXT.
REQ-026 NEXT: remaining count decrements; address increments modulo 2^ADDR_LEN (wrap 2^ADDR_LEN-1 -> 0); if remaining becomes 0 pulse done and go IDLE, else go READ.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE next cycle, deassert tx_wr_req, no done pulse; a byte transferring in that same cycle counts as sent.
REQ-028 abort in IDLE SHALL have no effect; abort and start in same IDLE cycle: abort wins.
REQ-029 ram_rd_en and tx_wr_req SHALL never be high in the same cycle.
REQ-030 Word latency start->first tx_wr_req SHALL be 3 cycles (READ, CAPTURE, SEND entry) with ready high.

Reset
REQ-031 rstb=0 SHALL immediately force IDLE and outputs busy=0, done=0, ram_rd_en=0, ram_addr=0, tx_wr_req=0, tx_wr_data=0; internal counters/buffer to 0.
REQ-032 Reset mid-dump SHALL discard the dump without a done pulse; after release block idles until a new start.

Verification
REQ-033 start_addr=0x10, word_cnt=2, RAM[0x10]=0x44332211, RAM[0x11]=0x88776655, ready=1 -> bytes 11,22,33,44,55,66,77,88 then single done pulse.
REQ-034 word_cnt=0 start -> done pulse next cycle, no ram_rd_en, no tx_wr_req.
REQ-035 start_addr=0x3FFF, word_cnt=2 -> reads at 0x3FFF then 0x0000.
REQ-036 tx_wr_ready toggled randomly -> tx_wr_data stable while req pending, byte sequence unchanged, no byte lost or duplicated.
REQ-037 abort asserted during second byte of word 0 -> IDLE next cycle, tx_wr_req=0, no done; new start then works normally.
REQ-038 rstb pulsed low mid-SEND -> outputs at reset values asynchronously, busy=0, no done after release.
